// File: rtl/key_line_buffer_pkg.sv
// Shared keyboard definitions: key codes, ASCII bases and the line-editor state type.
// The caps-lock FSM imports KEY_CAPS from here so both blocks agree on the code.
package key_line_buffer_pkg;

  localparam logic [4:0] NUM_LETTERS = 5'd26;
  localparam logic [4:0] KEY_BKSP    = 5'd26;
  localparam logic [4:0] KEY_CAPS    = 5'd27;
  localparam logic [4:0] KEY_ENTER   = 5'd28;
  localparam logic [4:0] KEY_SPACE   = 5'd29;

  localparam logic [7:0] ASCII_UPPER_BASE = 8'h41;
  localparam logic [7:0] ASCII_LOWER_BASE = 8'h61;
  localparam logic [7:0] ASCII_SPACE      = 8'h20;

  typedef enum logic {
    EDIT,
    COMMIT
  } line_state_e;

endpackage

// File: rtl/key_to_ascii.sv
// Combinational key-code to ASCII translation; also used by the display stage.
// Only letters and space are printable; every other code reports printable=0.
module key_to_ascii
  import key_line_buffer_pkg::*;
(
  input  logic [4:0] digit,
  input  logic       capital,
  output logic       printable,
  output logic [7:0] ascii
);

  // Letters map onto a contiguous ASCII run chosen by the caps state.
  always_comb begin
    printable = 1'b0;
    ascii     = ASCII_SPACE;
    if (digit < NUM_LETTERS) begin
      printable = 1'b1;
      ascii     = (capital ? ASCII_UPPER_BASE : ASCII_LOWER_BASE) + {3'b000, digit};
    end else if (digit == KEY_SPACE) begin
      printable = 1'b1;
      ascii     = ASCII_SPACE;
    end
  end

endmodule

// File: rtl/key_line_buffer.sv
// Single-line text editor: collects key presses into a DEPTH-character buffer,
// supports backspace, and hands the line downstream on enter via ready/ack.
// A registered random-access read port lets the display scan the line.
module key_line_buffer
  import key_line_buffer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          key_valid,
  input  logic [4:0]    digit,
  input  logic          capital,
  input  logic          line_ack,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_char,
  output logic [AW:0]   len,
  output logic          full,
  output logic          line_ready,
  output logic [7:0]    drop_cnt
);

  localparam logic [AW:0] LEN_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] LEN_FULL = {1'b1, {AW{1'b0}}};

  line_state_e state, next_state;

  logic [7:0] mem [DEPTH];

  logic       printable;
  logic [7:0] ascii;
  logic       key_write;
  logic       key_drop;
  logic       key_bksp;
  logic       key_enter;
  logic       take_ack;

  key_to_ascii u_key_to_ascii (
    .digit     (digit),
    .capital   (capital),
    .printable (printable),
    .ascii     (ascii)
  );

  assign full     = (len == LEN_FULL);
  assign take_ack = (state == COMMIT) && line_ack;

  // Classify the current press into one action; presses that cannot be stored are counted as drops.
  always_comb begin
    key_write = 1'b0;
    key_drop  = 1'b0;
    key_bksp  = 1'b0;
    key_enter = 1'b0;
    if (key_valid) begin
      if (printable) begin
        if ((state == EDIT) && !full) begin
          key_write = 1'b1;
        end else begin
          key_drop = 1'b1;
        end
      end else begin
        case (digit)
          KEY_BKSP:  key_bksp  = (state == EDIT) && (len != '0);
          KEY_ENTER: key_enter = (state == EDIT);
          KEY_CAPS:  ;
          default:   ;
        endcase
      end
    end
  end

  // State register; reset drops any pending line immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EDIT;
    end else begin
      state <= next_state;
    end
  end

  // Enter freezes the line; ack releases it back to editing.
  always_comb begin
    next_state = state;
    case (state)
      EDIT:    if (key_enter) next_state = COMMIT;
      COMMIT:  if (line_ack)  next_state = EDIT;
      default: next_state = EDIT;
    endcase
  end

  // A committed line is advertised for the whole time we sit in COMMIT.
  always_comb begin
    line_ready = 1'b0;
    case (state)
      COMMIT:  line_ready = 1'b1;
      default: line_ready = 1'b0;
    endcase
  end

  // Line length: cleared on ack, grows on a stored character, shrinks on backspace.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len <= '0;
    end else if (take_ack) begin
      len <= '0;
    end else if (key_write) begin
      len <= len + LEN_ONE;
    end else if (key_bksp) begin
      len <= len - LEN_ONE;
    end
  end

  // Saturating count of printable presses that could not be stored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= 8'd0;
    end else if (key_drop && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

  // Character storage; contents beyond len are stale but masked on read.
  always_ff @(posedge clk) begin
    if (key_write) begin
      mem[len[AW-1:0]] <= ascii;
    end
  end

  // Registered read port; positions past the end of the line read as a space.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_char <= ASCII_SPACE;
    end else if ({1'b0, rd_addr} < len) begin
      rd_char <= mem[rd_addr];
    end else begin
      rd_char <= ASCII_SPACE;
    end
  end

endmodule

// File: tb/tb_key_line_buffer.sv
// Self-checking bench for key_line_buffer: directed scenarios with literal
// expectations, then randomized key traffic compared every cycle against a
// queue-based model of the edited line.
module tb_key_line_buffer;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          key_valid = 1'b0;
  logic [4:0]    digit = 5'd0;
  logic          capital = 1'b0;
  logic          line_ack = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [7:0]    rd_char;
  logic [AW:0]   len;
  logic          full;
  logic          line_ready;
  logic [7:0]    drop_cnt;

  int tests = 0;
  int fails = 0;
  bit check_en = 1'b0;

  logic [7:0]  line_q[$];
  bit          committed;
  int          drops;
  logic [7:0]  exp_rd;
  string       lower_s = "abcdefghijklmnopqrstuvwxyz";
  string       upper_s = "ABCDEFGHIJKLMNOPQRSTUVWXYZ";

  key_line_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_valid  (key_valid),
    .digit      (digit),
    .capital    (capital),
    .line_ack   (line_ack),
    .rd_addr    (rd_addr),
    .rd_char    (rd_char),
    .len        (len),
    .full       (full),
    .line_ready (line_ready),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  function automatic bit isPrintable(input logic [4:0] d);
    return (d < 5'd26) || (d == 5'd29);
  endfunction

  function automatic logic [7:0] charOf(input logic [4:0] d, input logic cap);
    if (d == 5'd29) return 8'h20;
    return cap ? upper_s[d] : lower_s[d];
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic kv, input logic [4:0] dg, input logic cap,
                               input logic ack, input logic [AW-1:0] addr);
    key_valid = kv;
    digit     = dg;
    capital   = cap;
    line_ack  = ack;
    rd_addr   = addr;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    line_ack  = 1'b0;
  endtask

  task automatic press(input logic [4:0] dg, input logic cap);
    applyStimulus(1'b1, dg, cap, 1'b0, rd_addr);
  endtask

  task automatic readAt(input logic [AW-1:0] addr, input int expected, input string name);
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, addr);
    checkOutput(name, rd_char, expected);
  endtask

  // Behavioural model: the line is a queue of characters, commit is a flag.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_q.delete();
      committed = 1'b0;
      drops     = 0;
      exp_rd    = 8'h20;
    end else begin
      exp_rd = (int'(rd_addr) < line_q.size()) ? line_q[rd_addr] : 8'h20;
      if (committed) begin
        if (key_valid && isPrintable(digit) && drops < 255) drops++;
        if (line_ack) begin
          line_q.delete();
          committed = 1'b0;
        end
      end else if (key_valid) begin
        if (isPrintable(digit)) begin
          if (line_q.size() < DEPTH) line_q.push_back(charOf(digit, capital));
          else if (drops < 255) drops++;
        end else if (digit == 5'd26) begin
          if (line_q.size() > 0) void'(line_q.pop_back());
        end else if (digit == 5'd28) begin
          committed = 1'b1;
        end
      end
    end
  end

  // Every cycle, outputs must match the model.
  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("len", len, line_q.size());
      checkOutput("full", full, (line_q.size() == DEPTH) ? 1 : 0);
      checkOutput("line_ready", line_ready, committed ? 1 : 0);
      checkOutput("drop_cnt", drop_cnt, drops);
      checkOutput("rd_char", rd_char, exp_rd);
    end
  end

  initial begin
    #12;
    rst_n = 1'b1;
    #1;
    check_en = 1'b1;
    checkOutput("reset_len", len, 0);
    checkOutput("reset_full", full, 0);
    checkOutput("reset_ready", line_ready, 0);
    checkOutput("reset_drop", drop_cnt, 0);
    checkOutput("reset_rd_char", rd_char, 8'h20);

    // Lower-case then upper-case letters.
    press(5'd7, 1'b0);
    press(5'd8, 1'b0);
    checkOutput("len_after_hi", len, 2);
    readAt(4'd0, 8'h68, "rd_char_0_h");
    readAt(4'd1, 8'h69, "rd_char_1_i");
    press(5'd0, 1'b1);
    readAt(4'd2, 8'h41, "rd_char_2_A");
    readAt(4'd3, 8'h20, "rd_char_past_len");

    // Empty the line, then fill and overflow.
    for (int i = 0; i < 3; i++) press(5'd26, 1'b0);
    checkOutput("len_emptied", len, 0);
    for (int i = 0; i < DEPTH; i++) press(5'd29, 1'b0);
    checkOutput("full_after_16", full, 1);
    for (int i = 0; i < 3; i++) press(5'd3, 1'b1);
    checkOutput("len_overflow", len, 16);
    checkOutput("drop_overflow", drop_cnt, 3);
    press(5'd26, 1'b0);
    checkOutput("len_bksp_full", len, 15);
    checkOutput("full_bksp", full, 0);

    // Backspace and caps at empty.
    for (int i = 0; i < 15; i++) press(5'd26, 1'b0);
    press(5'd26, 1'b0);
    press(5'd26, 1'b0);
    checkOutput("len_bksp_empty", len, 0);
    checkOutput("drop_bksp_empty", drop_cnt, 3);
    press(5'd27, 1'b1);
    checkOutput("len_caps", len, 0);

    // Commit handshake.
    press(5'd0, 1'b0);
    press(5'd1, 1'b0);
    press(5'd28, 1'b0);
    checkOutput("ready_commit", line_ready, 1);
    checkOutput("len_commit", len, 2);
    press(5'd5, 1'b0);
    checkOutput("len_frozen", len, 2);
    checkOutput("drop_in_commit", drop_cnt, 4);
    readAt(4'd1, 8'h62, "rd_char_frozen");
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b1, 4'd0);
    checkOutput("len_after_ack", len, 0);
    checkOutput("ready_after_ack", line_ready, 0);
    press(5'd2, 1'b0);
    checkOutput("len_new_line", len, 1);
    readAt(4'd0, 8'h63, "rd_char_new_line");

    // Simultaneous key and ack, then empty commit.
    press(5'd28, 1'b0);
    applyStimulus(1'b1, 5'd4, 1'b0, 1'b1, 4'd0);
    checkOutput("ready_sim", line_ready, 0);
    checkOutput("len_sim", len, 0);
    checkOutput("drop_sim", drop_cnt, 5);
    press(5'd28, 1'b0);
    checkOutput("ready_empty_commit", line_ready, 1);
    checkOutput("len_empty_commit", len, 0);

    // Asynchronous reset while committed, between clock edges.
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_len", len, 0);
    checkOutput("async_ready", line_ready, 0);
    checkOutput("async_drop", drop_cnt, 0);
    checkOutput("async_full", full, 0);
    checkOutput("async_rd_char", rd_char, 8'h20);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Randomized traffic checked by the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      int r;
      logic [4:0] d;
      r = $urandom_range(0, 99);
      if (r < 6)       d = 5'd28;
      else if (r < 18) d = 5'd26;
      else             d = 5'($urandom_range(0, 31));
      if (i == 1500) begin
        #2;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
      end
      applyStimulus(1'($urandom_range(0, 1)), d, 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) == 0), AW'($urandom_range(0, DEPTH - 1)));
    end

    @(posedge clk);
    #1;
    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
